// File: rtl/tcdm_banks_pipe_pkg.sv
// Shared types for the banked TCDM: init FSM states, the response pipeline
// stage record and the latency bound.
package tcdm_banks_pipe_pkg;
  typedef enum logic {INIT, READY} state_e;

  localparam int MaxLatency = 4;
  localparam int MaxIdWidth = 32;

  typedef struct packed {
    logic                  valid;
    logic [MaxIdWidth-1:0] id;
    logic                  is_read;
  } resp_stage_t;
endpackage

// File: rtl/tcdm_banks_pipe_if.sv
// Per-bank request/response bus of tcdm_banks_pipe, one bit/word per bank.
interface tcdm_banks_pipe_if #(
  parameter int NbBanks   = 1,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int BeWidth   = DataWidth/8,
  parameter int IdWidth   = 1
);
  logic [NbBanks-1:0]                req_i;
  logic [NbBanks-1:0]                gnt_o;
  logic [NbBanks-1:0]                wen_i;
  logic [NbBanks-1:0][AddrWidth-1:0] add_i;
  logic [NbBanks-1:0][DataWidth-1:0] data_i;
  logic [NbBanks-1:0][BeWidth-1:0]   be_i;
  logic [NbBanks-1:0][IdWidth-1:0]   id_i;
  logic [NbBanks-1:0][DataWidth-1:0] r_data_o;
  logic [NbBanks-1:0]                r_valid_o;
  logic [NbBanks-1:0][IdWidth-1:0]   r_id_o;
  logic [NbBanks-1:0]                r_err_o;

  modport master (output req_i, wen_i, add_i, data_i, be_i, id_i,
                  input  gnt_o, r_data_o, r_valid_o, r_id_o, r_err_o);
  modport slave  (input  req_i, wen_i, add_i, data_i, be_i, id_i,
                  output gnt_o, r_data_o, r_valid_o, r_id_o, r_err_o);
endinterface

// File: rtl/tcdm_bank_sram.sv
// Single-port byte-enabled bank array with a registered read port.
// TCDM_BANKS_PIPE_PARITY_EN adds one even-parity bit per byte and a read error flag.
module tcdm_bank_sram
  import tcdm_banks_pipe_pkg::*;
#(
  parameter int BankSize  = 256,
  parameter int DataWidth = 32,
  parameter int BeWidth   = DataWidth/8
) (
  input  logic                        clk_i,
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [$clog2(BankSize)-1:0] addr_i,
  input  logic [DataWidth-1:0]        wdata_i,
  input  logic [BeWidth-1:0]          be_i,
  output logic [DataWidth-1:0]        rdata_o,
  output logic                        err_o
);
  localparam int ByteW = DataWidth/BeWidth;

  logic [BeWidth-1:0][ByteW-1:0] mem [BankSize];
  logic [BeWidth-1:0][ByteW-1:0] wbytes;

  assign wbytes = wdata_i;

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < BeWidth; b++)
          if (be_i[b]) mem[addr_i][b] <= wbytes[b];
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

`ifdef TCDM_BANKS_PIPE_PARITY_EN
  logic [BeWidth-1:0] par [BankSize];
  logic [BeWidth-1:0] par_chk;

  // A set bit means the stored byte no longer matches its stored parity.
  always_comb begin
    par_chk = '0;
    for (int b = 0; b < BeWidth; b++)
      par_chk[b] = (^mem[addr_i][b]) ^ par[addr_i][b];
  end

  always_ff @(posedge clk_i) begin
    if (req_i) begin
      if (we_i) begin
        for (int b = 0; b < BeWidth; b++)
          if (be_i[b]) par[addr_i][b] <= ^wbytes[b];
      end else begin
        err_o <= |par_chk;
      end
    end
  end
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: rtl/tcdm_banks_pipe.sv
// Banked TCDM with zero-init FSM and a fixed-latency response pipeline per bank.
// Optional parity via TCDM_BANKS_PIPE_PARITY_EN.
module tcdm_banks_pipe
  import tcdm_banks_pipe_pkg::*;
#(
  parameter int BankSize  = 256,
  parameter int NbBanks   = 1,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int BeWidth   = DataWidth/8,
  parameter int IdWidth   = 1,
  parameter int Latency   = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             test_mode_i,
  tcdm_banks_pipe_if.slave bus,
  output logic             init_done_o
);
  localparam int IdxW = $clog2(BankSize);

  if (Latency < 1 || Latency > MaxLatency) begin : g_lat_err
    $error("tcdm_banks_pipe: Latency must be within 1..%0d", MaxLatency);
  end

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            gnt_all, init_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // test_mode_i is only honoured on the first INIT cycle, i.e. right after reset.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      if ((test_mode_i && idx_q == '0) || idx_q == IdxW'(BankSize-1)) state_d = READY;
      else idx_d = idx_q + IdxW'(1);
    end
  end

  always_comb begin
    gnt_all = (state_q == READY);
    init_we = (state_q == INIT) && !(test_mode_i && idx_q == '0);
  end

  assign init_done_o = gnt_all;

  for (genvar b = 0; b < NbBanks; b++) begin : g_bank
    logic                  acc, sram_req, sram_we, sram_err, fin_err;
    logic [IdxW-1:0]       sram_addr;
    logic [DataWidth-1:0]  sram_wdata, sram_rdata, fin_data, hold_data;
    logic [BeWidth-1:0]    sram_be;
    logic [IdWidth-1:0]    hold_id;
    resp_stage_t [Latency-1:0] stg;
    resp_stage_t           fin;
    logic                  unused_bits;

    assign acc            = bus.req_i[b] & gnt_all;
    assign bus.gnt_o[b]   = gnt_all;
    assign unused_bits    = ^{bus.add_i[b], fin.id};

    always_comb begin
      sram_req   = acc | init_we;
      sram_we    = init_we | ~bus.wen_i[b];
      sram_addr  = init_we ? idx_q : bus.add_i[b][IdxW+1:2];
      sram_wdata = init_we ? '0 : bus.data_i[b];
      sram_be    = init_we ? '1 : bus.be_i[b];
    end

    tcdm_bank_sram #(
      .BankSize (BankSize),
      .DataWidth(DataWidth),
      .BeWidth  (BeWidth)
    ) u_sram (
      .clk_i,
      .req_i  (sram_req),
      .we_i   (sram_we),
      .addr_i (sram_addr),
      .wdata_i(sram_wdata),
      .be_i   (sram_be),
      .rdata_o(sram_rdata),
      .err_o  (sram_err)
    );

    // Stage 0 is captured on the same edge the array is read, so stg[s]
    // lines up with the array data delayed by s cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stg <= '0;
      end else begin
        stg[0] <= '{valid: acc, id: MaxIdWidth'(bus.id_i[b]), is_read: bus.wen_i[b]};
        for (int s = 1; s < Latency; s++) stg[s] <= stg[s-1];
      end
    end

    if (Latency == 1) begin : g_l1
      assign fin_data = sram_rdata;
      assign fin_err  = sram_err;
    end else begin : g_ln
      logic [Latency-1:1][DataWidth-1:0] dat_q;
      logic [Latency-1:1]                err_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          dat_q <= '0;
          err_q <= '0;
        end else begin
          dat_q[1] <= sram_rdata;
          err_q[1] <= sram_err;
          for (int s = 2; s < Latency; s++) begin
            dat_q[s] <= dat_q[s-1];
            err_q[s] <= err_q[s-1];
          end
        end
      end
      assign fin_data = dat_q[Latency-1];
      assign fin_err  = err_q[Latency-1];
    end

    assign fin = stg[Latency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        hold_data <= '0;
        hold_id   <= '0;
      end else if (fin.valid) begin
        hold_data <= fin.is_read ? fin_data : '0;
        hold_id   <= fin.id[IdWidth-1:0];
      end
    end

    assign bus.r_valid_o[b] = fin.valid;
    assign bus.r_data_o[b]  = fin.valid ? (fin.is_read ? fin_data : '0) : hold_data;
    assign bus.r_id_o[b]    = fin.valid ? fin.id[IdWidth-1:0] : hold_id;
    assign bus.r_err_o[b]   = fin.valid & fin.is_read & fin_err;
  end
endmodule

// File: tb/tb_tcdm_banks_pipe.sv
// Directed bench for tcdm_banks_pipe: dut a (BankSize 256, Latency 3) and
// dut b (BankSize 16, Latency 2), both with four banks.
module tb_tcdm_banks_pipe;
  localparam int NB = 4, DW = 32, AW = 32, BW = 4, IW = 2;

  logic clk_i = 1'b0;
  logic rst_i, tm_a, tm_b, done_a, done_b;
  int   total = 0, bad = 0;

  always #5 clk_i = ~clk_i;

  tcdm_banks_pipe_if #(.NbBanks(NB), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .IdWidth(IW)) bus_a ();
  tcdm_banks_pipe_if #(.NbBanks(NB), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW), .IdWidth(IW)) bus_b ();

  tcdm_banks_pipe #(.BankSize(256), .NbBanks(NB), .DataWidth(DW), .AddrWidth(AW), .BeWidth(BW),
                    .IdWidth(IW), .Latency(3)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_mode_i(tm_a), .bus(bus_a.slave), .init_done_o(done_a));

  tcdm_banks_pipe #(.BankSize(16), .NbBanks(NB), .DataWidth(DW), .AddrWidth(AW), .BeWidth(BW),
                    .IdWidth(IW), .Latency(2)) u_dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .test_mode_i(tm_b), .bus(bus_b.slave), .init_done_o(done_b));

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    bus_a.req_i = '0; bus_a.wen_i = '1; bus_a.add_i = '0; bus_a.data_i = '0; bus_a.be_i = '0; bus_a.id_i = '0;
    bus_b.req_i = '0; bus_b.wen_i = '1; bus_b.add_i = '0; bus_b.data_i = '0; bus_b.be_i = '0; bus_b.id_i = '0;
  endtask

  task automatic drv_a(int b, logic wen, logic [31:0] add, logic [31:0] data, logic [3:0] be, logic [1:0] id);
    bus_a.req_i = '0; bus_a.req_i[b] = 1'b1;
    bus_a.wen_i[b] = wen; bus_a.add_i[b] = add; bus_a.data_i[b] = data;
    bus_a.be_i[b] = be; bus_a.id_i[b] = id;
  endtask

  task automatic test_reset();
    int n, early;
    rst_i = 1'b1; tm_a = 1'b0; tm_b = 1'b0; idle();
    repeat (2) tick();
    total++; if (bus_a.gnt_o !== 4'h0) begin bad++; $display("FAIL rst_gnt: got %h exp 0", bus_a.gnt_o); end
    total++; if (done_a !== 1'b0) begin bad++; $display("FAIL rst_done: got %b exp 0", done_a); end
    total++; if (bus_a.r_valid_o !== 4'h0) begin bad++; $display("FAIL rst_valid: got %h exp 0", bus_a.r_valid_o); end
    total++; if (bus_a.r_data_o !== '0 || bus_a.r_id_o !== '0) begin bad++; $display("FAIL rst_data_id: got %h/%h exp 0/0", bus_a.r_data_o, bus_a.r_id_o); end
    total++; if (bus_a.r_err_o !== 4'h0) begin bad++; $display("FAIL rst_err: got %h exp 0", bus_a.r_err_o); end
    rst_i = 1'b0;
    n = 0; early = 0;
    while (done_a !== 1'b1 && n < 400) begin
      if (bus_a.gnt_o !== 4'h0) early++;
      n++; tick();
    end
    total++; if (n !== 256) begin bad++; $display("FAIL init_cycles: got %0d exp 256", n); end
    total++; if (early !== 0) begin bad++; $display("FAIL init_gnt: got %0d grant cycles exp 0", early); end
    total++; if (bus_a.gnt_o !== 4'hF) begin bad++; $display("FAIL ready_gnt: got %h exp f", bus_a.gnt_o); end
  endtask

  // Word 17 and the last word (255) both come back zeroed after init.
  task automatic test_init_read();
    bus_a.req_i = 4'b1001; bus_a.wen_i = '1; bus_a.be_i = '0;
    bus_a.add_i[0] = 32'h44; bus_a.id_i[0] = 2'd2;
    bus_a.add_i[3] = 32'h3FC; bus_a.id_i[3] = 2'd3;
    tick(); idle(); tick();
    total++; if (bus_a.r_valid_o !== 4'h0) begin bad++; $display("FAIL init_rd_early: got %h exp 0", bus_a.r_valid_o); end
    tick();
    total++; if (bus_a.r_valid_o !== 4'b1001) begin bad++; $display("FAIL init_rd_valid: got %h exp 9", bus_a.r_valid_o); end
    total++; if (bus_a.r_data_o[0] !== 32'h0 || bus_a.r_data_o[3] !== 32'h0) begin bad++; $display("FAIL init_rd_data: got %h/%h exp 0/0", bus_a.r_data_o[0], bus_a.r_data_o[3]); end
    total++; if (bus_a.r_id_o[0] !== 2'd2 || bus_a.r_id_o[3] !== 2'd3) begin bad++; $display("FAIL init_rd_id: got %0d/%0d exp 2/3", bus_a.r_id_o[0], bus_a.r_id_o[3]); end
    tick();
  endtask

  // Write then read of the same word on consecutive cycles; the read address
  // carries junk in the ignored low and high bits.
  task automatic test_write_read();
    drv_a(0, 1'b0, 32'h14, 32'hDEADBEEF, 4'hF, 2'd1); tick();
    drv_a(0, 1'b1, 32'hF000_0017, 32'h0, 4'h0, 2'd0); tick();
    idle();
    total++; if (bus_a.r_valid_o !== 4'h0) begin bad++; $display("FAIL wr_rsp_early: got %h exp 0", bus_a.r_valid_o); end
    tick();
    total++; if (bus_a.r_valid_o !== 4'b0001) begin bad++; $display("FAIL wr_rsp_valid: got %h exp 1", bus_a.r_valid_o); end
    total++; if (bus_a.r_id_o[0] !== 2'd1 || bus_a.r_data_o[0] !== 32'h0) begin bad++; $display("FAIL wr_rsp: got id %0d data %h exp 1/0", bus_a.r_id_o[0], bus_a.r_data_o[0]); end
    tick();
    total++; if (bus_a.r_valid_o !== 4'b0001) begin bad++; $display("FAIL rd_rsp_valid: got %h exp 1", bus_a.r_valid_o); end
    total++; if (bus_a.r_id_o[0] !== 2'd0 || bus_a.r_data_o[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rsp: got id %0d data %h exp 0/deadbeef", bus_a.r_id_o[0], bus_a.r_data_o[0]); end
    tick();
    total++; if (bus_a.r_valid_o !== 4'h0) begin bad++; $display("FAIL rsp_tail: got %h exp 0", bus_a.r_valid_o); end
    total++; if (bus_a.r_data_o[0] !== 32'hDEADBEEF || bus_a.r_id_o[0] !== 2'd0) begin bad++; $display("FAIL rsp_hold: got %h/%0d exp deadbeef/0", bus_a.r_data_o[0], bus_a.r_id_o[0]); end
  endtask

  task automatic test_partial_write();
    drv_a(1, 1'b0, 32'h80, 32'h11223344, 4'hF, 2'd2); tick();
    drv_a(1, 1'b0, 32'h80, 32'h00AB0000, 4'b0100, 2'd3); tick();
    drv_a(1, 1'b1, 32'h80, 32'hFFFFFFFF, 4'h0, 2'd1); tick();
    idle();
    total++; if (bus_a.r_valid_o !== 4'b0010 || bus_a.r_data_o[1] !== 32'h0 || bus_a.r_id_o[1] !== 2'd2) begin
      bad++; $display("FAIL pw_wr_rsp: got v%h d%h id%0d exp v2 d0 id2", bus_a.r_valid_o, bus_a.r_data_o[1], bus_a.r_id_o[1]); end
    repeat (2) tick();
    total++; if (bus_a.r_valid_o !== 4'b0010) begin bad++; $display("FAIL pw_rd_valid: got %h exp 2", bus_a.r_valid_o); end
    total++; if (bus_a.r_data_o[1] !== 32'h11AB3344 || bus_a.r_id_o[1] !== 2'd1) begin bad++; $display("FAIL pw_rd_data: got %h/%0d exp 11ab3344/1", bus_a.r_data_o[1], bus_a.r_id_o[1]); end
    tick();
  endtask

`ifdef TCDM_BANKS_PIPE_PARITY_EN
  task automatic test_parity();
    drv_a(0, 1'b0, 32'h24, 32'hCAFEF00D, 4'hF, 2'd0); tick();
    drv_a(0, 1'b0, 32'h28, 32'h12345678, 4'hF, 2'd1); tick();
    u_dut.g_bank[0].u_sram.mem[9] = u_dut.g_bank[0].u_sram.mem[9] ^ 32'h0001_0000;
    drv_a(0, 1'b1, 32'h24, 32'h0, 4'h0, 2'd2); tick();
    drv_a(0, 1'b1, 32'h28, 32'h0, 4'h0, 2'd3);
    total++; if (bus_a.r_valid_o[0] !== 1'b1 || bus_a.r_err_o[0] !== 1'b0) begin bad++; $display("FAIL par_wr_err: got v%b e%b exp 1/0", bus_a.r_valid_o[0], bus_a.r_err_o[0]); end
    tick(); idle(); tick();
    total++; if (bus_a.r_valid_o[0] !== 1'b1 || bus_a.r_err_o[0] !== 1'b1 || bus_a.r_data_o[0] !== 32'hCAFFF00D) begin
      bad++; $display("FAIL par_flip: got v%b e%b d%h exp 1/1/caff f00d", bus_a.r_valid_o[0], bus_a.r_err_o[0], bus_a.r_data_o[0]); end
    tick();
    total++; if (bus_a.r_valid_o[0] !== 1'b1 || bus_a.r_err_o[0] !== 1'b0 || bus_a.r_data_o[0] !== 32'h12345678) begin
      bad++; $display("FAIL par_clean: got v%b e%b d%h exp 1/0/12345678", bus_a.r_valid_o[0], bus_a.r_err_o[0], bus_a.r_data_o[0]); end
    tick();
  endtask
`endif

  // Fill all 16 words of every bank on dut b, then stream 16 reads per bank.
  task automatic test_back_to_back();
    int cnt[NB], first[NB], last[NB];
    for (int i = 0; i < 16; i++) begin
      bus_b.req_i = '1; bus_b.wen_i = '0; bus_b.be_i = '1;
      for (int b = 0; b < NB; b++) begin
        bus_b.add_i[b] = 32'(i*4); bus_b.data_i[b] = {8'(b+1), 16'h5A5A, 8'(i)}; bus_b.id_i[b] = 2'(i);
      end
      tick();
    end
    bus_b.req_i = '0; repeat (3) tick();
    for (int b = 0; b < NB; b++) begin cnt[b] = 0; first[b] = -1; last[b] = -1; end
    for (int k = 0; k < 22; k++) begin
      if (k < 16) begin
        bus_b.req_i = '1; bus_b.wen_i = '1; bus_b.be_i = '0;
        for (int b = 0; b < NB; b++) begin bus_b.add_i[b] = 32'((b << 12) | (k*4)); bus_b.id_i[b] = 2'(k+1); end
      end else bus_b.req_i = '0;
      for (int b = 0; b < NB; b++) if (bus_b.r_valid_o[b] === 1'b1) begin
        total++;
        if (bus_b.r_data_o[b] !== {8'(b+1), 16'h5A5A, 8'(cnt[b])} || bus_b.r_id_o[b] !== 2'(cnt[b]+1)) begin
          bad++; $display("FAIL b2b_data bank%0d #%0d: got %h/%0d exp %h/%0d", b, cnt[b], bus_b.r_data_o[b], bus_b.r_id_o[b], {8'(b+1), 16'h5A5A, 8'(cnt[b])}, 2'(cnt[b]+1));
        end
        if (first[b] < 0) first[b] = k;
        last[b] = k; cnt[b]++;
      end
      tick();
    end
    for (int b = 0; b < NB; b++) begin
      total++;
      if (cnt[b] !== 16 || first[b] !== 2 || last[b] !== 17) begin
        bad++; $display("FAIL b2b_stream bank%0d: got cnt %0d first %0d last %0d exp 16/2/17", b, cnt[b], first[b], last[b]);
      end
    end
  endtask

  // Reset with two reads in flight; dut b comes back via test mode.
  task automatic test_reset_inflight();
    int n, stray;
    drv_a(0, 1'b1, 32'h14, 32'h0, 4'h0, 2'd1); tick();
    drv_a(2, 1'b1, 32'h80, 32'h0, 4'h0, 2'd2); tick();
    idle(); rst_i = 1'b1; tm_b = 1'b1; #1;
    total++; if (bus_a.r_valid_o !== 4'h0 || bus_a.r_data_o !== '0) begin bad++; $display("FAIL rst_fly: got v%h d%h exp 0/0", bus_a.r_valid_o, bus_a.r_data_o); end
    tick(); rst_i = 1'b0;
    n = 0; stray = 0;
    while (done_a !== 1'b1 && n < 400) begin
      if (bus_a.r_valid_o !== 4'h0 || bus_a.gnt_o !== 4'h0) stray++;
      if (n == 0) begin total++; if (done_b !== 1'b0) begin bad++; $display("FAIL tm_early: got %b exp 0", done_b); end end
      if (n == 1) begin total++; if (done_b !== 1'b1) begin bad++; $display("FAIL tm_bypass: got %b exp 1", done_b); end end
      n++; tick();
    end
    total++; if (stray !== 0) begin bad++; $display("FAIL rst_stray: got %0d cycles exp 0", stray); end
    total++; if (n !== 256) begin bad++; $display("FAIL reinit_cycles: got %0d exp 256", n); end
    drv_a(0, 1'b1, 32'h14, 32'h0, 4'h0, 2'd3); tick(); idle(); repeat (2) tick();
    total++; if (bus_a.r_valid_o !== 4'b0001 || bus_a.r_data_o[0] !== 32'h0) begin bad++; $display("FAIL reinit_data: got v%h d%h exp 1/0", bus_a.r_valid_o, bus_a.r_data_o[0]); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_write_read();
    test_partial_write();
`ifdef TCDM_BANKS_PIPE_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tcdm_banks_pipe.md
TCDM_BANKS_PIPE -- requirements
Module: tcdm_banks_pipe

Interface
REQ-001 SHALL have parameter BankSize, default 256, words per bank (power of two, >=2).
REQ-002 SHALL have parameter NbBanks, default 1, number of independent banks.
REQ-003 SHALL have parameter DataWidth, default 32, word width (multiple of 8).
REQ-004 SHALL have parameters AddrWidth, default 32, request address width; BeWidth, default DataWidth/8, byte enables.
REQ-005 SHALL have parameters IdWidth, default 1, request ID width; Latency, default 1, read latency in cycles (1..4, elaboration error otherwise).
REQ-006 SHALL have ports clk_i in 1 (clock); rst_i in 1 (reset, asynchronous, active-high); test_mode_i in 1 (skip init).
REQ-007 SHALL have per-bank ports [NbBanks]: req_i in 1; gnt_o out 1; wen_i in 1 (1=read, 0=write); add_i in AddrWidth; data_i in DataWidth; be_i in BeWidth; id_i in IdWidth.
REQ-008 SHALL have per-bank response ports [NbBanks]: r_data_o out DataWidth; r_valid_o out 1; r_id_o out IdWidth; r_err_o out 1.
REQ-009 SHALL have init_done_o out 1, high once banks are initialised.

Function
REQ-010 SHALL implement FSM INIT -> READY; INIT writes zero with all byte enables to word index 0..BankSize-1 in all banks in parallel, one word per cycle.
REQ-011 SHALL move INIT -> READY in the cycle after index BankSize-1 is written (BankSize cycles in INIT); READY is terminal until reset.
REQ-012 SHALL enter READY directly on first clock after reset release if test_mode_i=1 at that edge, leaving contents uninitialised.
REQ-013 SHALL drive gnt_o=0 and init_done_o=0 in INIT; gnt_o=1 for all banks and init_done_o=1 in READY.
REQ-014 SHALL accept a request when req_i&gnt_o; word index = add_i[$clog2(BankSize)+1:2]; add_i[1:0] and upper bits ignored.
REQ-015 SHALL on accepted write update only bytes with be_i set; on accepted read ignore be_i.
REQ-016 SHALL assert r_valid_o exactly Latency cycles after every accepted request (read or write), fully pipelined, one response per bank per cycle.
REQ-017 SHALL return with r_valid_o the read word for reads, zero for writes, and r_id_o equal to the accepted id_i.
REQ-018 SHALL hold r_data_o and r_id_o at their last values while r_valid_o=0.
REQ-019 SHALL return newly written data for a read accepted the cycle after a write to the same word.
REQ-020 SHALL keep banks fully independent; no cross-bank arbitration or stall.

Reset
REQ-021 SHALL on rst_i force FSM to INIT, init index 0, all pipeline valids 0, r_valid_o=0, r_data_o=0, r_id_o=0, r_err_o=0, gnt_o=0, init_done_o=0.
REQ-022 SHALL on reset during INIT or READY discard in-flight responses and restart initialisation from index 0 (unless test_mode_i bypasses it).

Configuration
REQ-023 SHALL with macro TCDM_BANKS_PIPE_PARITY_EN defined store one even-parity bit per byte, written with its byte (init writes parity 0).
REQ-024 SHALL with TCDM_BANKS_PIPE_PARITY_EN defined assert r_err_o with r_valid_o on a read whose any stored byte parity mismatches; r_err_o=0 for writes.
REQ-025 SHALL without TCDM_BANKS_PIPE_PARITY_EN keep port r_err_o, tied to 0, and allocate no parity storage.

Structure
REQ-026 SHALL place in package tcdm_banks_pipe_pkg the FSM state enum (INIT, READY), the MaxLatency=4 constant and the response-stage struct (valid, id, is_read).
REQ-027 SHALL instantiate one sub-module tcdm_bank_sram per bank: single-port, byte-enabled, 1-cycle array; Latency-1 extra output register stages live in the top.

Verification
REQ-028 SHALL cover reset release, test_mode_i=0, BankSize=256 -> gnt_o=0 for 256 cycles, init_done_o=1 on cycle 257, read of word 17 returns 0x00000000.
REQ-029 SHALL cover Latency=3: write 0xDEADBEEF to word 5 (id 1), read word 5 next cycle (id 0) -> r_valid_o at +3 and +4, second returns 0xDEADBEEF, r_id_o 1 then 0.
REQ-030 SHALL cover partial write be_i=4'b0100 data 0x00AB0000 over word 0x11223344 -> read returns 0x11AB3344.
REQ-031 SHALL cover back-to-back reads every cycle for 16 cycles, Latency=2, NbBanks=4 -> 16 contiguous r_valid_o per bank, in order, no gaps.
REQ-032 SHALL cover rst_i pulse with 2 reads in flight -> no r_valid_o afterwards, INIT restarts from index 0.
REQ-033 SHALL cover TCDM_BANKS_PIPE_PARITY_EN with forced bit flip in stored byte 2 -> next read r_err_o=1 with r_valid_o; clean word -> r_err_o=0.
